// File: rtl/div_ctrl_pkg.sv
// Shared types and defaults for the div_ctrl divide-by-N tick scheduler.
package div_ctrl_pkg;

  localparam int unsigned DIV_W_DEF = 8;
  localparam int unsigned DIV_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Number of high phases in a ~50% duty period: ceil(n/2).
  function automatic int unsigned half_period(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/div_ctrl_counter.sv
// Phase counter for div_ctrl: clear-to-zero, enable, wrap at limit-1.
module div_ctrl_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_phase,
  output logic         o_is_last
);

  logic [W-1:0] r_phase;

  assign o_phase   = r_phase;
  assign o_is_last = (r_phase == (i_limit - W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (i_clr) begin
      r_phase <= '0;
    end else if (i_en) begin
      r_phase <= o_is_last ? '0 : r_phase + W'(1);
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Divide-by-N tick scheduler with shadowed ratio updates at period boundaries.
// Define DIV_CTRL_DUTY50_EN to get a registered ~50% duty clk_div output.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned W       = DIV_W_DEF,
  parameter int unsigned DEF_DIV = DIV_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         tick,
  output logic         clk_div,
  output logic         busy,
  output logic [W-1:0] cur_div
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_div;
  logic [W-1:0] r_shadow;
  logic         r_full;
  logic         r_err;
  logic [W-1:0] w_phase;
  logic         w_is_last;
  logic         w_boundary;
  logic         w_apply;
  logic         w_accept;
  logic         w_clr;
  logic         w_cnt_en;

  // IDLE is always a boundary, so a pending ratio lands one cycle after accept.
  assign w_boundary = (r_state == IDLE) || w_is_last;
  assign w_apply    = r_full && w_boundary;
  assign w_accept   = cfg_valid && !r_full;
  assign w_cnt_en   = (r_state != IDLE);
  assign w_clr      = (r_state == IDLE) || ((r_state == DRAIN) && !en && w_is_last);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (en) w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = DRAIN;
      DRAIN: begin
        if (en)             w_state_nxt = RUN;
        else if (w_is_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  div_ctrl_counter #(.W(W)) u_counter (
    .clk       (clk),
    .rst_n     (reset),
    .i_clr     (w_clr),
    .i_en      (w_cnt_en),
    .i_limit   (r_div),
    .o_phase   (w_phase),
    .o_is_last (w_is_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_div    <= W'(DEF_DIV);
      r_shadow <= '0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_accept && (cfg_div == '0);
      if (w_apply) begin
        r_div  <= r_shadow;
        r_full <= 1'b0;
      end else if (w_accept && (cfg_div != '0)) begin
        r_shadow <= cfg_div;
        r_full   <= 1'b1;
      end
    end
  end

  assign cfg_ready = !r_full;
  assign cfg_err   = r_err;
  assign busy      = (r_state != IDLE);
  assign tick      = (r_state != IDLE) && (w_phase == '0);
  assign cur_div   = r_div;

`ifdef DIV_CTRL_DUTY50_EN
  logic [W-1:0] w_phase_nxt;
  logic [W-1:0] w_div_nxt;
  logic         r_clk_div;

  // Registered from next-cycle state/phase/ratio so the rising edge lines up with tick.
  always_comb begin
    w_phase_nxt = w_phase;
    if (w_clr)         w_phase_nxt = '0;
    else if (w_cnt_en) w_phase_nxt = w_is_last ? '0 : w_phase + W'(1);
  end

  assign w_div_nxt = w_apply ? r_shadow : r_div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_div <= 1'b0;
    end else begin
      r_clk_div <= (w_state_nxt != IDLE) &&
                   (32'(w_phase_nxt) < half_period(32'(w_div_nxt)));
    end
  end

  assign clk_div = r_clk_div;
`else
  assign clk_div = 1'b0;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl (W=8, DEF_DIV=3).
module tb_div_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       tick;
  logic       clk_div;
  logic       busy;
  logic [7:0] cur_div;

  int errors = 0;
  int checks = 0;

  div_ctrl #(.W(8), .DEF_DIV(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .clk_div   (clk_div),
    .busy      (busy),
    .cur_div   (cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    step();
    while (tick !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL wait_tick: tick=%b, required 1 within 40 cycles", tick);
    end
  endtask

  task automatic wait_div(input logic [7:0] want);
    int n;
    n = 0;
    while (cur_div !== want && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (cur_div !== want) begin
      errors++;
      $display("FAIL wait_div: cur_div=%0d, required %0d within 40 cycles", cur_div, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    #12;
    checks += 6;
    if (tick !== 1'b0)      begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    if (cfg_err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    if (clk_div !== 1'b0)   begin errors++; $display("FAIL reset_clkdiv: got %b want 0", clk_div); end
    if (cur_div !== 8'd3)   begin errors++; $display("FAIL reset_curdiv: got %0d want 3", cur_div); end
    reset = 1'b1;
    step();
    step();
  endtask

  task automatic test_run_default();
    logic exp;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL run_idle_busy: got %b want 0", busy); end
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = ((k - 1) % 3 == 0);
      checks += 3;
      if (tick !== exp)     begin errors++; $display("FAIL run_tick k=%0d: got %b want %b", k, tick, exp); end
      if (busy !== 1'b1)    begin errors++; $display("FAIL run_busy k=%0d: got %b want 1", k, busy); end
      if (cur_div !== 8'd3) begin errors++; $display("FAIL run_curdiv k=%0d: got %0d want 3", k, cur_div); end
    end
  endtask

  task automatic test_cfg_change();
    wait_tick();
    step();
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_before: got %b want 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    checks += 3;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_pending: got %b want 0", cfg_ready); end
    if (cur_div !== 8'd3)   begin errors++; $display("FAIL cfg_curdiv_pending: got %0d want 3", cur_div); end
    if (tick !== 1'b0)      begin errors++; $display("FAIL cfg_tick_pending: got %b want 0", tick); end
    step();
    checks += 3;
    if (tick !== 1'b1)      begin errors++; $display("FAIL cfg_tick_boundary: got %b want 1", tick); end
    if (cur_div !== 8'd5)   begin errors++; $display("FAIL cfg_curdiv_applied: got %0d want 5", cur_div); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_after: got %b want 1", cfg_ready); end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (tick !== (i == 5)) begin errors++; $display("FAIL cfg_spacing5 i=%0d: got %b want %b", i, tick, (i == 5)); end
    end
  endtask

  task automatic test_cfg_zero();
    step();
    cfg_valid = 1'b1; cfg_div = 8'd0;
    step();
    cfg_valid = 1'b0;
    checks += 3;
    if (cfg_err !== 1'b1)   begin errors++; $display("FAIL zero_err_pulse: got %b want 1", cfg_err); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", cfg_ready); end
    if (cur_div !== 8'd5)   begin errors++; $display("FAIL zero_curdiv: got %0d want 5", cur_div); end
    step();
    checks += 2;
    if (cfg_err !== 1'b0)   begin errors++; $display("FAIL zero_err_end: got %b want 0", cfg_err); end
    if (cur_div !== 8'd5)   begin errors++; $display("FAIL zero_curdiv_later: got %0d want 5", cur_div); end
  endtask

  task automatic test_drain();
    cfg_valid = 1'b1; cfg_div = 8'd4;
    step();
    cfg_valid = 1'b0;
    wait_div(8'd4);
    wait_tick();
    step();
    en = 1'b0;
    step();
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_p2: got %b want 1", busy); end
    if (tick !== 1'b0) begin errors++; $display("FAIL drain_tick_p2: got %b want 0", tick); end
    step();
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_p3: got %b want 1", busy); end
    if (tick !== 1'b0) begin errors++; $display("FAIL drain_tick_p3: got %b want 0", tick); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL drain_idle_busy i=%0d: got %b want 0", i, busy); end
      if (tick !== 1'b0) begin errors++; $display("FAIL drain_idle_tick i=%0d: got %b want 0", i, tick); end
    end
    en = 1'b1;
    wait_tick();
    step();
    en = 1'b0;
    step();
    en = 1'b1;
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL rearm_busy: got %b want 1", busy); end
    if (tick !== 1'b0) begin errors++; $display("FAIL rearm_tick_p2: got %b want 0", tick); end
    step();
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL rearm_tick_p3: got %b want 0", tick); end
    step();
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL rearm_tick_p0: got %b want 1", tick); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (tick !== (i == 4)) begin errors++; $display("FAIL rearm_spacing4 i=%0d: got %b want %b", i, tick, (i == 4)); end
    end
  endtask

  task automatic test_reset_mid();
    logic exp;
    step();
    cfg_valid = 1'b1; cfg_div = 8'd7;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b want 0", cfg_ready); end
    reset = 1'b0; en = 1'b0;
    #1;
    checks += 6;
    if (tick !== 1'b0)      begin errors++; $display("FAIL rstmid_tick: got %b want 0", tick); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", cfg_ready); end
    if (cfg_err !== 1'b0)   begin errors++; $display("FAIL rstmid_err: got %b want 0", cfg_err); end
    if (clk_div !== 1'b0)   begin errors++; $display("FAIL rstmid_clkdiv: got %b want 0", clk_div); end
    if (cur_div !== 8'd3)   begin errors++; $display("FAIL rstmid_curdiv: got %0d want 3", cur_div); end
    step();
    step();
    #2;
    reset = 1'b1;
    step();
    en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp = ((k - 1) % 3 == 0);
      checks += 2;
      if (tick !== exp)     begin errors++; $display("FAIL rstmid_tick k=%0d: got %b want %b", k, tick, exp); end
      if (cur_div !== 8'd3) begin errors++; $display("FAIL rstmid_no7 k=%0d: got %0d want 3", k, cur_div); end
    end
  endtask

  task automatic test_duty();
`ifdef DIV_CTRL_DUTY50_EN
    logic exp;
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    wait_div(8'd5);
    for (int i = 0; i < 10; i++) begin
      exp = ((i % 5) < 3);
      checks += 2;
      if (clk_div !== exp)        begin errors++; $display("FAIL duty_clkdiv i=%0d: got %b want %b", i, clk_div, exp); end
      if (tick !== (i % 5 == 0))  begin errors++; $display("FAIL duty_tick i=%0d: got %b want %b", i, tick, (i % 5 == 0)); end
      step();
    end
`else
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (clk_div !== 1'b0) begin errors++; $display("FAIL duty_off_clkdiv i=%0d: got %b want 0", i, clk_div); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_run_default();
    test_cfg_change();
    test_cfg_zero();
    test_drain();
    test_reset_mid();
    test_duty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
